// File: rtl/parity_frame_gen_pkg.sv
// rtl/parity_frame_gen_pkg.sv - shared defaults, state type and parity helper for parity_frame_gen
package parity_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    // Callers zero-extend narrower words; the extra zero bits do not change the XOR.
    function automatic logic par_reduce(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_gen_if.sv
// rtl/parity_frame_gen_if.sv - handshake bundle for parity_frame_gen (PARITY_CHECK_EN adds check signals)
interface parity_frame_gen_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              mode_odd;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par;
    logic              out_last;
    logic              out_frame_par;
    logic [CNT_W-1:0]  out_frame_len;
    logic              busy;
`ifdef PARITY_CHECK_EN
    logic              in_par_exp;
    logic              out_par_err;
    logic              out_frame_err;

    modport master (
        output mode_odd, in_valid, in_data, in_last, out_ready, in_par_exp,
        input  in_ready, out_valid, out_data, out_par, out_last,
               out_frame_par, out_frame_len, busy, out_par_err, out_frame_err
    );
    modport slave (
        input  mode_odd, in_valid, in_data, in_last, out_ready, in_par_exp,
        output in_ready, out_valid, out_data, out_par, out_last,
               out_frame_par, out_frame_len, busy, out_par_err, out_frame_err
    );
`else
    modport master (
        output mode_odd, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_par, out_last,
               out_frame_par, out_frame_len, busy
    );
    modport slave (
        input  mode_odd, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_par, out_last,
               out_frame_par, out_frame_len, busy
    );
`endif
endinterface

// File: rtl/parity_frame_gen_word_calc.sv
// rtl/parity_frame_gen_word_calc.sv - combinational word parity with even/odd mode bit
module parity_word_calc
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data,
    input  logic              odd,
    output logic              par
);

    assign par = par_reduce(64'(data), odd);

endmodule

// File: rtl/parity_frame_gen.sv
// rtl/parity_frame_gen.sv - streaming word/frame parity generator, one registered stage; PARITY_CHECK_EN adds parity checking
module parity_frame_gen
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    parity_frame_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic              busy_c;

    logic              acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_next;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_par_q;
    logic              out_last_q;
    logic              out_frame_par_q;
    logic [CNT_W-1:0]  out_frame_len_q;

    logic              in_ready_c;
    logic              accept;
    logic              word_par;
    logic              raw_par;
    logic              frame_par_next;

    parity_word_calc #(.DATA_W(DATA_W)) u_word (
        .data (bus.in_data),
        .odd  (bus.mode_odd),
        .par  (word_par)
    );

    // Mode-free parity feeds the accumulator; the mode bit is applied once at frame close.
    parity_word_calc #(.DATA_W(DATA_W)) u_raw (
        .data (bus.in_data),
        .odd  (1'b0),
        .par  (raw_par)
    );

    assign in_ready_c     = !out_valid_q || bus.out_ready;
    assign accept         = bus.in_valid && in_ready_c;
    assign frame_par_next = acc_q ^ raw_par ^ bus.mode_odd;
    assign len_next       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = bus.in_last ? IDLE : IN_FRAME;
        end
    end

    always_comb begin
        busy_c = (state_q == IN_FRAME);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            if (bus.in_last) begin
                acc_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_q ^ raw_par;
                cnt_q <= len_next;
            end
        end
    end

    // Output stage reloads on accept even while emitting, giving one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_par_q       <= 1'b0;
            out_last_q      <= 1'b0;
            out_frame_par_q <= 1'b0;
            out_frame_len_q <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data;
            out_par_q   <= word_par;
            out_last_q  <= bus.in_last;
            if (bus.in_last) begin
                out_frame_par_q <= frame_par_next;
                out_frame_len_q <= len_next;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    logic word_err;
    logic ferr_acc_q;
    logic out_par_err_q;
    logic out_frame_err_q;

    assign word_err = bus.in_par_exp != word_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_acc_q      <= 1'b0;
            out_par_err_q   <= 1'b0;
            out_frame_err_q <= 1'b0;
        end else if (accept) begin
            out_par_err_q <= word_err;
            if (bus.in_last) begin
                out_frame_err_q <= ferr_acc_q | word_err;
                ferr_acc_q      <= 1'b0;
            end else begin
                ferr_acc_q <= ferr_acc_q | word_err;
            end
        end
    end

    assign bus.out_par_err   = out_par_err_q;
    assign bus.out_frame_err = out_frame_err_q;
`endif

    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_par       = out_par_q;
    assign bus.out_last      = out_last_q;
    assign bus.out_frame_par = out_frame_par_q;
    assign bus.out_frame_len = out_frame_len_q;
    assign bus.busy          = busy_c;

endmodule

// File: tb/tb_parity_frame_gen.sv
// tb/tb_parity_frame_gen.sv - self-checking bench for parity_frame_gen (honours PARITY_CHECK_EN)
module tb_parity_frame_gen;

    localparam int DW     = 8;
    localparam int CW     = 8;
    localparam int CW_SAT = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        logic          last;
        logic          fpar;
        int            len;
        int            slen;
        logic          err;
        logic          ferr;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    parity_frame_gen_if #(.DATA_W(DW), .CNT_W(CW))     bus ();
    parity_frame_gen_if #(.DATA_W(DW), .CNT_W(CW_SAT)) bus_s ();

    parity_frame_gen #(.DATA_W(DW), .CNT_W(CW))     dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    parity_frame_gen #(.DATA_W(DW), .CNT_W(CW_SAT)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    assign bus_s.mode_odd  = bus.mode_odd;
    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in_data   = bus.in_data;
    assign bus_s.in_last   = bus.in_last;
    assign bus_s.out_ready = bus.out_ready;
`ifdef PARITY_CHECK_EN
    assign bus_s.in_par_exp = bus.in_par_exp;
`endif

    int            checks = 0;
    int            errors = 0;
    rec_t          sb[$];
    rec_t          emit_log[$];
    logic [DW-1:0] frame_words[$];
    logic          ferr_model = 1'b0;
    logic          prev_acc = 1'b0;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic m,
                         input logic r, input logic pe, output logic accepted);
        rec_t e;
        rec_t o;
        logic wp;
        int   ones;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.mode_odd  = m;
        bus.out_ready = r;
`ifdef PARITY_CHECK_EN
        bus.in_par_exp = pe;
`endif
        #1;
        checks++;
        if (bus.in_ready !== (!bus.out_valid || r)) begin
            errors++; $display("FAIL in_ready got %b exp %b", bus.in_ready, !bus.out_valid || r);
        end
        checks++;
        if (bus.busy !== (frame_words.size() != 0)) begin
            errors++; $display("FAIL busy got %b exp %b", bus.busy, frame_words.size() != 0);
        end
        checks++;
        if (bus_s.out_valid !== bus.out_valid || bus_s.busy !== bus.busy) begin
            errors++; $display("FAIL sat_dut_valid got %b exp %b", bus_s.out_valid, bus.out_valid);
        end
        if (prev_acc) begin
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL latency out_valid got %b exp 1", bus.out_valid);
            end
        end
        if (bus.out_valid === 1'b1) begin
            o.data = bus.out_data; o.par = bus.out_par; o.last = bus.out_last;
            o.fpar = bus.out_frame_par; o.len = int'(bus.out_frame_len);
            o.slen = int'(bus_s.out_frame_len);
`ifdef PARITY_CHECK_EN
            o.err = bus.out_par_err; o.ferr = bus.out_frame_err;
`else
            o.err = 1'b0; o.ferr = 1'b0;
`endif
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL spurious_output got data %h exp none", o.data);
            end else begin
                e = sb[0];
                if (o.data !== e.data || o.par !== e.par || o.last !== e.last ||
                    bus_s.out_data !== e.data || bus_s.out_par !== e.par) begin
                    errors++;
                    $display("FAIL word got data %h par %b last %b exp data %h par %b last %b",
                             o.data, o.par, o.last, e.data, e.par, e.last);
                end
                if (e.last) begin
                    checks++;
                    if (o.fpar !== e.fpar || o.len != e.len || o.slen != e.slen ||
                        bus_s.out_frame_par !== e.fpar) begin
                        errors++;
                        $display("FAIL frame got fpar %b len %0d slen %0d exp fpar %b len %0d slen %0d",
                                 o.fpar, o.len, o.slen, e.fpar, e.len, e.slen);
                    end
                end
`ifdef PARITY_CHECK_EN
                checks++;
                if (o.err !== e.err || (e.last && o.ferr !== e.ferr)) begin
                    errors++;
                    $display("FAIL par_err got err %b ferr %b exp err %b ferr %b", o.err, o.ferr, e.err, e.ferr);
                end
`endif
                if (r) begin
                    void'(sb.pop_front());
                    emit_log.push_back(o);
                end
            end
        end
        accepted = v && bus.in_ready;
        if (accepted) begin
            wp = (($countones(d) % 2) == 1) ^ m;
            frame_words.push_back(d);
            ferr_model = ferr_model | (pe != wp);
            e.data = d; e.par = wp; e.last = l; e.err = (pe != wp);
            e.fpar = 1'b0; e.len = 0; e.slen = 0; e.ferr = 1'b0;
            if (l) begin
                ones = 0;
                foreach (frame_words[i]) ones += $countones(frame_words[i]);
                e.fpar = ((ones % 2) == 1) ^ m;
                e.len  = min_int(frame_words.size(), (1 << CW) - 1);
                e.slen = min_int(frame_words.size(), (1 << CW_SAT) - 1);
                e.ferr = ferr_model;
                frame_words.delete();
                ferr_model = 1'b0;
            end
            sb.push_back(e);
        end
        prev_acc = accepted;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l, input logic m, input logic pe);
        logic a;
        int   n;
        n = 0;
        a = 1'b0;
        while (!a && n < 16) begin
            cycle(1'b1, d, l, m, 1'b1, pe, a);
            n++;
        end
        if (!a) begin
            checks++; errors++; $display("FAIL send_timeout got not accepted exp accepted");
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, a);
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_par !== 1'b0 ||
            bus.out_last !== 1'b0 || bus.out_frame_par !== 1'b0 || bus.out_frame_len !== '0 ||
            bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus_s.out_valid !== 1'b0 ||
            bus_s.out_frame_len !== '0) begin
            errors++;
            $display("FAIL %s got valid %b data %h par %b flen %0d busy %b exp all zero, in_ready 1",
                     tag, bus.out_valid, bus.out_data, bus.out_par, bus.out_frame_len, bus.busy);
        end
`ifdef PARITY_CHECK_EN
        checks++;
        if (bus.out_par_err !== 1'b0 || bus.out_frame_err !== 1'b0) begin
            errors++; $display("FAIL %s_err got %b%b exp 00", tag, bus.out_par_err, bus.out_frame_err);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.mode_odd = 1'b0; bus.out_ready = 1'b1;
`ifdef PARITY_CHECK_EN
        bus.in_par_exp = 1'b0;
`endif
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_words();
        logic [DW-1:0] words[4];
        logic          pars[4];
        words = '{8'h00, 8'h01, 8'h03, 8'h07};
        pars  = '{1'b0, 1'b1, 1'b0, 1'b1};
        emit_log.delete();
        for (int i = 0; i < 4; i++) send(words[i], 1'b1, 1'b0, pars[i]);
        idle(2);
        checks++;
        if (emit_log.size() != 4) begin
            errors++; $display("FAIL single_count got %0d exp 4", emit_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (emit_log[i].par !== pars[i] || emit_log[i].fpar !== pars[i] || emit_log[i].len != 1) begin
                    errors++;
                    $display("FAIL single_%0d got par %b fpar %b len %0d exp par %b fpar %b len 1",
                             i, emit_log[i].par, emit_log[i].fpar, emit_log[i].len, pars[i], pars[i]);
                end
            end
        end
    endtask

    task automatic test_odd_frame();
        emit_log.delete();
        send(8'hFF, 1'b0, 1'b1, 1'b1);
        send(8'h01, 1'b0, 1'b1, 1'b0);
        send(8'h80, 1'b1, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (emit_log.size() != 3 || emit_log[0].par !== 1'b1 || emit_log[1].par !== 1'b0 ||
            emit_log[2].par !== 1'b0 || emit_log[2].fpar !== 1'b1 || emit_log[2].len != 3) begin
            errors++;
            $display("FAIL odd_frame got n %0d last fpar %b len %0d exp n 3 pars 100 fpar 1 len 3",
                     emit_log.size(), emit_log[emit_log.size()-1].fpar, emit_log[emit_log.size()-1].len);
        end
    endtask

    task automatic test_backpressure();
        logic a;
        logic [DW-1:0] w0, w1, w2;
        w0 = DW'($urandom); w1 = DW'($urandom); w2 = DW'($urandom);
        emit_log.delete();
        send(w0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, w1, 1'b0, 1'b0, 1'b0, 1'b0, a);
            checks++;
            if (a !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_%0d got in_ready %b exp 0", i, bus.in_ready);
            end
        end
        send(w1, 1'b0, 1'b0, 1'b0);
        send(w2, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (emit_log.size() != 3 || sb.size() != 0) begin
            errors++; $display("FAIL backpressure_count got %0d pending %0d exp 3 pending 0", emit_log.size(), sb.size());
        end
    endtask

    task automatic test_saturation();
        emit_log.delete();
        for (int i = 0; i < 6; i++) send(DW'($urandom), i == 5, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (emit_log.size() != 6 || emit_log[5].len != 6 || emit_log[5].slen != 3) begin
            errors++;
            $display("FAIL saturation got len %0d slen %0d exp len 6 slen 3",
                     emit_log[emit_log.size()-1].len, emit_log[emit_log.size()-1].slen);
        end
    endtask

    task automatic test_random();
        logic a;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 4) == 0,
                  1'($urandom), $urandom_range(0, 9) < 7, 1'($urandom), a);
        end
        send(DW'($urandom), 1'b1, 1'($urandom), 1'($urandom));
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL random_drain got pending %0d exp 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        send(DW'($urandom), 1'b0, 1'b0, 1'b0);
        send(DW'($urandom), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid_frame");
        sb.delete(); frame_words.delete(); ferr_model = 1'b0; prev_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        emit_log.delete();
        send(8'h01, 1'b1, 1'b0, 1'b1);
        idle(2);
        checks++;
        if (emit_log.size() != 1 || emit_log[0].fpar !== 1'b1 || emit_log[0].len != 1) begin
            errors++;
            $display("FAIL post_reset_frame got n %0d fpar %b len %0d exp n 1 fpar 1 len 1",
                     emit_log.size(), emit_log[0].fpar, emit_log[0].len);
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_par_check();
        emit_log.delete();
        send(8'h01, 1'b1, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'h03, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (emit_log.size() != 4 || emit_log[0].err !== 1'b1 || emit_log[0].ferr !== 1'b1 ||
            emit_log[1].err !== 1'b0 || emit_log[1].ferr !== 1'b0 ||
            emit_log[3].err !== 1'b0 || emit_log[3].ferr !== 1'b1) begin
            errors++;
            $display("FAIL par_check got n %0d err0 %b ferr0 %b ferr1 %b ferr3 %b exp n 4 1 1 0 1",
                     emit_log.size(), emit_log[0].err, emit_log[0].ferr, emit_log[1].ferr, emit_log[3].ferr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_words();
        test_odd_frame();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_mid_frame();
`ifdef PARITY_CHECK_EN
        test_par_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_gen.md
Name: parity_frame_gen

Overview:
Streaming parity generator, the parametrised successor to the 3-bit combinational even-parity generator. It accepts DATA_W-bit words over a valid/ready handshake, grouped into frames by a last flag. For each word it emits the word parity; on the last word of a frame it also emits the cumulative frame parity. Even or odd parity is selected at runtime. The block sits between a word source and a serialiser/link framer as a single registered pipeline stage.

Parameters:
DATA_W, 8, data word width in bits (1..64)
CNT_W, 8, width of frame word counter; counter saturates at 2^CNT_W-1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
mode_odd  in  1  0 = even parity, 1 = odd parity; sampled on each accepted input word
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
in_data  in  DATA_W  input word
in_last  in  1  word is last of frame
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output
out_data  out  DATA_W  registered copy of accepted word
out_par  out  1  word parity: XOR of out_data bits XOR mode_odd
out_last  out  1  registered in_last
out_frame_par  out  1  frame parity, meaningful only when out_valid && out_last
out_frame_len  out  CNT_W  words in frame including this one, saturating; meaningful when out_valid && out_last
busy  out  1  1 while in IN_FRAME state

Behaviour:
- Reset (async assert, sync-release as seen by logic): out_valid=0, out_data=0, out_par=0, out_last=0, out_frame_par=0, out_frame_len=0, state=IDLE, accumulator=0, counter=0, busy=0.
- Handshake: accept = in_valid && in_ready; emit = out_valid && out_ready. in_ready = !out_valid || out_ready (full-throughput single-stage register; no combinational path from in_valid to out_valid).
- Latency 1 cycle: a word accepted at edge N appears on out_* after edge N; back-to-back throughput 1 word/cycle while out_ready=1.
- Output held stable while out_valid && !out_ready; in_data changes ignored (in_ready=0).
- Word parity: out_par = ^in_data ^ mode_odd, registered with the word.
- Frame accumulator acc (1 bit) and counter cnt (CNT_W) cover words accepted before the current one in the frame.
- On accept: frame_par_next = acc ^ (^in_data) ^ mode_odd; len_next = sat(cnt+1).
  - in_last=0: acc <= acc ^ (^in_data); cnt <= sat(cnt+1); state <= IN_FRAME.
  - in_last=1: out_frame_par <= frame_par_next; out_frame_len <= len_next; acc <= 0; cnt <= 0; state <= IDLE.
- mode_odd applies once per frame to frame parity, using the value sampled with the last word; it applies per word to out_par.
- Single-word frame (in_last on first word): out_frame_par = out_par, out_frame_len = 1.
- Counter saturation: at 2^CNT_W-1 it holds; frame parity is still exact.
- States: IDLE (no open frame) -> IN_FRAME on accept with in_last=0; IN_FRAME -> IDLE on accept with in_last=1; no other transitions.
- Simultaneous emit and accept in the same cycle: output register is reloaded with the new word; no bubble.
- Reset mid-frame: partial frame discarded, acc/cnt cleared, out_valid dropped immediately.

Optional Feature:
Macro PARITY_CHECK_EN. When defined: adds input in_par_exp (1) and output out_par_err (1). in_par_exp is sampled with an accepted word. out_par_err = registered (in_par_exp != computed word parity), valid with out_valid, reset 0. Additionally, sticky frame error: out_frame_err (1) = OR of word errors in the frame, presented with the last word and cleared when the frame closes. When not defined: these ports do not exist; all other behaviour is identical.

Decomposition:
- Package parity_pkg: parameter defaults (DATA_W_DEF=8, CNT_W_DEF=8), state enum typedef {IDLE, IN_FRAME}, and function par_reduce(data, odd) returning the reduction XOR plus the mode bit.
- One natural sub-module, parity_word_calc: combinational DATA_W reduction-XOR with mode input. It is reused for word and check parity.

Test Plan:
- Reset, then single-word frames in even mode, in_data 8'h00, 8'h01, 8'h03, 8'h07, in_last=1, out_ready=1 -> out_par 0,1,0,1; out_frame_par equals out_par; out_frame_len=1; 1-cycle latency.
- Odd mode, frame 8'hFF, 8'h01, 8'h80 (last) -> out_par 1,0,0; out_frame_par = 0^1^1^1 = 1; out_frame_len=3; busy 1 after the first word, 0 after the last.
- Backpressure: out_ready=0 for 3 cycles mid-frame -> in_ready=0, out_* stable; resume gives no loss or duplication, and frame parity is unchanged.
- Saturation with CNT_W=2: 6-word frame -> out_frame_len=3; frame parity correct.
- Async reset asserted mid-frame after 2 words, then a new 1-word frame 8'h01 even -> outputs are 0 during reset; new frame_par=1, len=1 (no stale accumulation).
- PARITY_CHECK_EN: frame of 8'h01 with in_par_exp=0 (even) -> out_par_err=1; out_frame_err=1 on the last word; the next clean frame gives out_frame_err=0.
